// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared definitions for the CPU memory path:
//   arb_state_t  - state encoding of the Avalon memory arbiter
//   BE_WORD      - byteenable for a full 32-bit word access
//   word_align() - clears the two byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Avalon addresses are word aligned; byte lanes are selected by byteenable.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/avalon_mem_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one Avalon-MM
// master. One access is outstanding at a time: IDLE -> GRANT_x -> RESP -> IDLE.
//
// Parameter:
//   DATA_PRIORITY   1: data port wins simultaneous requests, 0: fetch wins
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_req, i_addr               fetch request (held until i_done), byte address
//   i_rdata, i_done             fetched word, one-cycle completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_byteenable       data request (held until d_done) and payload
//   d_rdata, d_done             load word, one-cycle completion pulse
//   avm_*                       Avalon-MM master
//   stall                       freezes the CPU while an access is outstanding
// ---------------------------------------------------------------------------
module avalon_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter logic DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        stall
);

  arb_state_t  r_state;
  logic [31:0] r_i_rdata;
  logic        r_i_done;
  logic [31:0] r_d_rdata;
  logic        r_d_done;
  logic [31:0] r_avm_address;
  logic        r_avm_read;
  logic        r_avm_write;
  logic [31:0] r_avm_writedata;
  logic [3:0]  r_avm_byteenable;

  logic        w_grant_d;
  logic        w_grant_i;

  // Grant selection for the IDLE state; DATA_PRIORITY only breaks ties.
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (d_req && (!i_req || DATA_PRIORITY)) begin
      w_grant_d = 1'b1;
    end else if (i_req) begin
      w_grant_i = 1'b1;
    end else begin
      w_grant_d = 1'b0;
      w_grant_i = 1'b0;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_i_rdata        <= 32'h0000_0000;
      r_i_done         <= 1'b0;
      r_d_rdata        <= 32'h0000_0000;
      r_d_done         <= 1'b0;
      r_avm_address    <= 32'h0000_0000;
      r_avm_read       <= 1'b0;
      r_avm_write      <= 1'b0;
      r_avm_writedata  <= 32'h0000_0000;
      r_avm_byteenable <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          // Request payload is captured here so the requester may change it
          // while the access is in flight.
          if (w_grant_d) begin
            r_state          <= GRANT_D;
            r_avm_address    <= word_align(d_addr);
            r_avm_writedata  <= d_wdata;
            r_avm_byteenable <= d_byteenable;
            r_avm_read       <= ~d_we;
            r_avm_write      <= d_we;
          end else if (w_grant_i) begin
            r_state          <= GRANT_I;
            r_avm_address    <= word_align(i_addr);
            r_avm_byteenable <= BE_WORD;
            r_avm_read       <= 1'b1;
            r_avm_write      <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT_I: begin
          // avm_* simply hold while waitrequest is high.
          if (!avm_waitrequest) begin
            r_i_rdata   <= avm_readdata;
            r_i_done    <= 1'b1;
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_state <= GRANT_I;
          end
        end
        GRANT_D: begin
          if (!avm_waitrequest) begin
            // Writes leave the last load value in place.
            if (r_avm_read) begin
              r_d_rdata <= avm_readdata;
            end else begin
              r_d_rdata <= r_d_rdata;
            end
            r_d_done    <= 1'b1;
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_state <= GRANT_D;
          end
        end
        RESP: begin
          // Requests are not looked at here; the served port drops its req
          // during the following IDLE cycle, so a waiting port wins cleanly.
          r_i_done <= 1'b0;
          r_d_done <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_i_done    <= 1'b0;
          r_d_done    <= 1'b0;
          r_avm_read  <= 1'b0;
          r_avm_write <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata        = r_i_rdata;
  assign i_done         = r_i_done;
  assign d_rdata        = r_d_rdata;
  assign d_done         = r_d_done;
  assign avm_address    = r_avm_address;
  assign avm_read       = r_avm_read;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = r_avm_byteenable;

  // The done cycle releases the CPU even though req is still high then.
  assign stall = (i_req | d_req) & ~(r_i_done | r_d_done);

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter. Instance a uses DATA_PRIORITY=1,
// instance b uses DATA_PRIORITY=0; both share payload and waitrequest, and
// each has its own request lines and a small read-data model.
module tb_avalon_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        d_we, waitreq;
  logic [3:0]  d_be;

  logic        a_i_req, a_d_req, b_i_req, b_d_req;
  logic [31:0] a_i_rdata, a_d_rdata, a_addr, a_wdata, a_rd;
  logic [31:0] b_i_rdata, b_d_rdata, b_addr, b_wdata, b_rd;
  logic        a_i_done, a_d_done, a_read, a_write, a_stall;
  logic        b_i_done, b_d_done, b_read, b_write, b_stall;
  logic [3:0]  a_be, b_be;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Read-data model: the boot vector returns a fixed opcode, else a pattern.
  always_comb begin
    if (a_addr == 32'hBFC0_0000) a_rd = 32'h3C01_1234;
    else                         a_rd = a_addr ^ 32'h5A5A_0000;
    if (b_addr == 32'hBFC0_0000) b_rd = 32'h3C01_1234;
    else                         b_rd = b_addr ^ 32'h5A5A_0000;
  end

  avalon_mem_arbiter #(.DATA_PRIORITY(1'b1)) u_a (
    .clk(clk), .reset(reset),
    .i_req(a_i_req), .i_addr(i_addr), .i_rdata(a_i_rdata), .i_done(a_i_done),
    .d_req(a_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_be), .d_rdata(a_d_rdata), .d_done(a_d_done),
    .avm_address(a_addr), .avm_read(a_read), .avm_write(a_write),
    .avm_writedata(a_wdata), .avm_byteenable(a_be), .avm_readdata(a_rd),
    .avm_waitrequest(waitreq), .stall(a_stall)
  );

  avalon_mem_arbiter #(.DATA_PRIORITY(1'b0)) u_b (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(i_addr), .i_rdata(b_i_rdata), .i_done(b_i_done),
    .d_req(b_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_be), .d_rdata(b_d_rdata), .d_done(b_d_done),
    .avm_address(b_addr), .avm_read(b_read), .avm_write(b_write),
    .avm_writedata(b_wdata), .avm_byteenable(b_be), .avm_readdata(b_rd),
    .avm_waitrequest(waitreq), .stall(b_stall)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic ir, input logic dr);
    a_i_req = ir; b_i_req = ir;
    a_d_req = dr; b_d_req = dr;
  endtask

  task automatic test_reset();
    reset = 1'b1; waitreq = 1'b0; d_we = 1'b0; d_be = 4'b0000;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    drive_req(1'b0, 1'b0);
    tick(); tick();
    n_checks++; if ({a_read, a_write, a_i_done, a_d_done, a_stall} !== 5'b00000) begin n_errors++; $display("FAIL reset_a_ctrl got=%b exp=00000", {a_read, a_write, a_i_done, a_d_done, a_stall}); end
    n_checks++; if ({a_i_rdata, a_d_rdata, a_addr, a_wdata, a_be} !== 132'h0) begin n_errors++; $display("FAIL reset_a_data got=%h exp=0", {a_i_rdata, a_d_rdata, a_addr, a_wdata, a_be}); end
    n_checks++; if ({b_read, b_write, b_i_done, b_d_done, b_stall} !== 5'b00000) begin n_errors++; $display("FAIL reset_b_ctrl got=%b exp=00000", {b_read, b_write, b_i_done, b_d_done, b_stall}); end
    n_checks++; if ({b_i_rdata, b_d_rdata, b_addr, b_wdata, b_be} !== 132'h0) begin n_errors++; $display("FAIL reset_b_data got=%h exp=0", {b_i_rdata, b_d_rdata, b_addr, b_wdata, b_be}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    // cycle 1: IDLE with req raised
    i_addr = 32'hBFC0_0000; waitreq = 1'b0;
    drive_req(1'b1, 1'b0);
    #1;
    n_checks++; if (a_stall !== 1'b1) begin n_errors++; $display("FAIL fetch_stall_c1 got=%b exp=1", a_stall); end
    tick(); // cycle 2: GRANT_I
    i_addr = 32'h0000_0044; // changing the address after grant has no effect
    n_checks++; if ({a_read, a_write, a_be} !== 6'b10_1111) begin n_errors++; $display("FAIL fetch_grant_ctrl got=%b exp=101111", {a_read, a_write, a_be}); end
    n_checks++; if (a_addr !== 32'hBFC0_0000) begin n_errors++; $display("FAIL fetch_addr got=%h exp=bfc00000", a_addr); end
    n_checks++; if ({a_i_done, a_stall} !== 2'b01) begin n_errors++; $display("FAIL fetch_c2 done/stall got=%b exp=01", {a_i_done, a_stall}); end
    tick(); // cycle 3: RESP
    n_checks++; if ({a_i_done, a_d_done, a_read, a_stall} !== 4'b1000) begin n_errors++; $display("FAIL fetch_resp got=%b exp=1000", {a_i_done, a_d_done, a_read, a_stall}); end
    n_checks++; if (a_i_rdata !== 32'h3C01_1234) begin n_errors++; $display("FAIL fetch_rdata got=%h exp=3c011234", a_i_rdata); end
    n_checks++; if (b_i_rdata !== 32'h3C01_1234) begin n_errors++; $display("FAIL fetch_rdata_b got=%h exp=3c011234", b_i_rdata); end
    drive_req(1'b0, 1'b0);
    tick(); // IDLE
    n_checks++; if ({a_i_done, a_read, a_stall} !== 3'b000) begin n_errors++; $display("FAIL fetch_after got=%b exp=000", {a_i_done, a_read, a_stall}); end
    n_checks++; if (a_i_rdata !== 32'h3C01_1234) begin n_errors++; $display("FAIL fetch_hold got=%h exp=3c011234", a_i_rdata); end
  endtask

  task automatic test_data_read();
    d_we = 1'b0; d_addr = 32'h0000_2002; d_be = 4'b1111; waitreq = 1'b0;
    drive_req(1'b0, 1'b1);
    tick(); // GRANT_D
    n_checks++; if ({a_read, a_write, a_addr} !== {2'b10, 32'h0000_2000}) begin n_errors++; $display("FAIL dread_grant got=%b/%h exp=10/00002000", {a_read, a_write}, a_addr); end
    tick(); // RESP
    n_checks++; if ({a_d_done, a_i_done, a_stall} !== 3'b100) begin n_errors++; $display("FAIL dread_resp got=%b exp=100", {a_d_done, a_i_done, a_stall}); end
    n_checks++; if (a_d_rdata !== 32'h5A5A_2000) begin n_errors++; $display("FAIL dread_rdata got=%h exp=5a5a2000", a_d_rdata); end
    n_checks++; if (a_i_rdata !== 32'h3C01_1234) begin n_errors++; $display("FAIL dread_irdata got=%h exp=3c011234", a_i_rdata); end
    drive_req(1'b0, 1'b0);
    tick();
  endtask

  task automatic test_write_waitstates();
    d_we = 1'b1; d_addr = 32'h0000_1003; d_wdata = 32'hDEAD_BEEF; d_be = 4'b1000;
    waitreq = 1'b1;
    drive_req(1'b0, 1'b1);
    tick(); // cycle 2: GRANT_D, first waitstate
    d_addr = 32'h0000_7777; d_wdata = 32'h1111_1111; d_be = 4'b0001; d_we = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) waitreq = 1'b0;
      n_checks++; if ({a_read, a_write, a_addr, a_wdata, a_be} !== {2'b01, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1000}) begin n_errors++; $display("FAIL write_stable c%0d got=%b/%h/%h/%b", c, {a_read, a_write}, a_addr, a_wdata, a_be); end
      n_checks++; if ({a_d_done, a_stall} !== 2'b01) begin n_errors++; $display("FAIL write_wait c%0d done/stall got=%b exp=01", c, {a_d_done, a_stall}); end
      tick();
    end
    // cycle 5: RESP
    n_checks++; if ({a_d_done, a_write, a_read, a_stall} !== 4'b1000) begin n_errors++; $display("FAIL write_resp got=%b exp=1000", {a_d_done, a_write, a_read, a_stall}); end
    n_checks++; if (a_d_rdata !== 32'h5A5A_2000) begin n_errors++; $display("FAIL write_rdata_kept got=%h exp=5a5a2000", a_d_rdata); end
    drive_req(1'b0, 1'b0);
    tick();
    n_checks++; if ({a_d_done, a_write} !== 2'b00) begin n_errors++; $display("FAIL write_after got=%b exp=00", {a_d_done, a_write}); end
  endtask

  task automatic test_priority();
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0; d_be = 4'b1111;
    waitreq = 1'b0;
    drive_req(1'b1, 1'b1);
    tick(); // cycle 2: a GRANT_D, b GRANT_I
    n_checks++; if (a_addr !== 32'h0000_0200) begin n_errors++; $display("FAIL prio1_first got=%h exp=00000200", a_addr); end
    n_checks++; if (b_addr !== 32'h0000_0100) begin n_errors++; $display("FAIL prio0_first got=%h exp=00000100", b_addr); end
    tick(); // cycle 3: RESP
    n_checks++; if ({a_d_done, a_i_done, a_stall} !== 3'b100) begin n_errors++; $display("FAIL prio1_done1 got=%b exp=100", {a_d_done, a_i_done, a_stall}); end
    n_checks++; if ({b_d_done, b_i_done, b_stall} !== 3'b010) begin n_errors++; $display("FAIL prio0_done1 got=%b exp=010", {b_d_done, b_i_done, b_stall}); end
    a_d_req = 1'b0; b_i_req = 1'b0;
    tick(); // cycle 4: IDLE, loser still waiting
    n_checks++; if ({a_read, a_i_done, a_stall, b_read, b_d_done, b_stall} !== 6'b001_001) begin n_errors++; $display("FAIL prio_idle got=%b exp=001001", {a_read, a_i_done, a_stall, b_read, b_d_done, b_stall}); end
    tick(); // cycle 5: second grant
    n_checks++; if ({a_read, a_addr} !== {1'b1, 32'h0000_0100}) begin n_errors++; $display("FAIL prio1_second got=%b/%h exp=1/00000100", a_read, a_addr); end
    n_checks++; if ({b_read, b_addr} !== {1'b1, 32'h0000_0200}) begin n_errors++; $display("FAIL prio0_second got=%b/%h exp=1/00000200", b_read, b_addr); end
    tick(); // cycle 6: RESP
    n_checks++; if ({a_i_done, a_d_done, a_i_rdata, a_d_rdata} !== {2'b10, 32'h5A5A_0100, 32'h5A5A_0200}) begin n_errors++; $display("FAIL prio1_end got=%b/%h/%h", {a_i_done, a_d_done}, a_i_rdata, a_d_rdata); end
    n_checks++; if ({b_i_done, b_d_done, b_i_rdata, b_d_rdata} !== {2'b01, 32'h5A5A_0100, 32'h5A5A_0200}) begin n_errors++; $display("FAIL prio0_end got=%b/%h/%h", {b_i_done, b_d_done}, b_i_rdata, b_d_rdata); end
    drive_req(1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    d_we = 1'b0; d_addr = 32'h0000_3000; waitreq = 1'b1;
    drive_req(1'b0, 1'b1);
    tick(); // GRANT_D waiting
    n_checks++; if (a_read !== 1'b1) begin n_errors++; $display("FAIL rmid_grant got=%b exp=1", a_read); end
    reset = 1'b1;
    tick();
    n_checks++; if ({a_read, a_write, a_d_done, a_addr, a_d_rdata} !== {3'b000, 64'h0}) begin n_errors++; $display("FAIL rmid_abort got=%b/%h/%h", {a_read, a_write, a_d_done}, a_addr, a_d_rdata); end
    drive_req(1'b0, 1'b0);
    reset = 1'b0; waitreq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if ({a_read, a_d_done, a_i_done} !== 3'b000) begin n_errors++; $display("FAIL rmid_quiet c%0d got=%b exp=000", c, {a_read, a_d_done, a_i_done}); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_read();
    test_write_waitstates();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avalon_mem_arbiter.md
AVALON_MEM_ARBITER -- requirements
Module: avalon_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIORITY, default 1; 1 = data port wins simultaneous requests, 0 = instruction port wins.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request; held until i_done.
REQ-005 SHALL have port i_addr  input  32  fetch byte address.
REQ-006 SHALL have ports i_rdata  output  32  fetched word, and i_done  output  1  one-cycle completion pulse.
REQ-007 SHALL have port d_req  input  1  data request; held until d_done.
REQ-008 SHALL have ports d_we  input  1  1=write/0=read; d_addr  input  32; d_wdata  input  32; d_byteenable  input  4.
REQ-009 SHALL have ports d_rdata  output  32  load word, and d_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have Avalon master ports avm_address  output  32; avm_read  output  1; avm_write  output  1; avm_writedata  output  32; avm_byteenable  output  4; avm_readdata  input  32; avm_waitrequest  input  1.
REQ-011 SHALL have port stall  output  1  freezes the CPU state machine while an access is outstanding.

Function
REQ-012 SHALL implement states IDLE, GRANT_I, GRANT_D, RESP.
REQ-013 IDLE: d_req only -> GRANT_D; i_req only -> GRANT_I; both -> port selected by DATA_PRIORITY; neither -> stay in IDLE.
REQ-014 On the grant edge, SHALL register the address, write data, byteenable and direction; the requester may change its inputs afterwards without effect.
REQ-015 GRANT_x SHALL drive avm_address = {addr[31:2],2'b00}; instruction byteenable = 4'b1111; data byteenable = registered d_byteenable.
REQ-016 avm_read and avm_write SHALL never be high together; a fetch always asserts avm_read.
REQ-017 While avm_waitrequest=1, all avm_* outputs SHALL remain stable.
REQ-018 On the first GRANT_x cycle with avm_waitrequest=0, SHALL capture avm_readdata for reads, and SHALL go to RESP on the next edge.
REQ-019 RESP SHALL pulse exactly one of i_done/d_done for one cycle, present the captured data on i_rdata/d_rdata, and return to IDLE.
REQ-020 avm_read and avm_write SHALL be 0 in IDLE and RESP.
REQ-021 A request seen during RESP from the port just served SHALL be ignored; that port deasserts its req in the cycle after done.
REQ-022 i_rdata/d_rdata SHALL hold their last value until the next read completes on the same port; writes SHALL leave d_rdata unchanged.
REQ-023 stall SHALL be combinational: (i_req|d_req) & ~(i_done|d_done).
REQ-024 Minimum latency SHALL be 3 cycles from req high in IDLE to done, with zero waitstates; each waitstate cycle adds one cycle.
REQ-025 A losing requester SHALL wait in IDLE and be granted on the cycle after RESP.

Reset
REQ-026 reset high at a clock edge SHALL force IDLE, clear avm_read, avm_write, i_done and d_done, and zero i_rdata, d_rdata, avm_address, avm_writedata and avm_byteenable.
REQ-027 Reset mid-transaction SHALL abort the access with no done pulse and no retry; reset has priority over all other transitions.

Structure
REQ-028 The state enum (arb_state_t) and the constant BE_WORD=4'b1111 SHALL live in a shared package, mips_cpu_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the CPU state machine consumes stall.

Verification
REQ-030 Fetch with zero waitstates: i_req=1, i_addr=0xBFC00000, readdata=0x3C011234 -> avm_read high 1 cycle, i_done at cycle 3, i_rdata=0x3C011234.
REQ-031 Write with 2 waitstates: d_we=1, d_addr=0x1003, d_wdata=0xDEADBEEF, be=4'b1000 -> avm_address=0x1000, outputs stable for 3 cycles, d_done at cycle 5, d_rdata unchanged.
REQ-032 Simultaneous i_req and d_req with DATA_PRIORITY=1 -> data served first, then fetch granted the cycle after d_done; with DATA_PRIORITY=0 the order is reversed.
REQ-033 Reset asserted during waitrequest -> next cycle state IDLE, avm_read=0, and no done pulse.
REQ-034 stall check across REQ-030..032 -> stall=1 from req until the done cycle, and stall=0 on the done cycle.
